// File: rtl/reg_scoreboard.sv
// Decode-stage register scoreboard for the 8x16 register file.
// Counts in-flight writes per architectural register, raises a combinational
// stall on read-after-write or counter-full hazards, retires writes on
// writeback, and keeps a saturating stall-cycle counter for debug.
module reg_scoreboard #(
  parameter int unsigned CNT_WIDTH  = 2,
  parameter int unsigned PERF_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic                  issue_wr,
  input  logic [2:0]            issue_dst,
  input  logic                  src1_used,
  input  logic [2:0]            src1_sel,
  input  logic                  src2_used,
  input  logic [2:0]            src2_sel,
  input  logic                  wb_valid,
  input  logic [2:0]            wb_sel,
  input  logic                  flush,
  output logic                  stall,
  output logic [7:0]            busy,
  output logic [PERF_WIDTH-1:0] stall_cnt,
  output logic                  err
);

  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  logic [CNT_WIDTH-1:0]  cnt_q [8];
  logic [CNT_WIDTH-1:0]  cnt_d [8];
  logic [PERF_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic                  err_q, err_d;
  logic                  src_hazard, wr_full, accept;

  // Hazard detection from registered counters only; a retire in the same
  // cycle does not bypass, the source is readable from the RF next cycle.
  always_comb begin
    src_hazard = (src1_used & (cnt_q[src1_sel] != '0)) |
                 (src2_used & (cnt_q[src2_sel] != '0));
    wr_full    = issue_wr & (cnt_q[issue_dst] == CntMax);
    stall      = ~rst & issue_valid & ~flush & (src_hazard | wr_full);
    accept     = issue_valid & ~stall & ~flush;
  end

  // Per-register counter update; an issue and retire to the same register
  // cancel, so a retire with zero pending is only an error without that issue.
  always_comb begin
    err_d = err_q;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = cnt_q[i];
      if (flush) begin
        cnt_d[i] = '0;
      end else if ((accept & issue_wr & (issue_dst == 3'(i))) &&
                   !(wb_valid && (wb_sel == 3'(i)))) begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end else if ((wb_valid && (wb_sel == 3'(i))) &&
                   !(accept & issue_wr & (issue_dst == 3'(i)))) begin
        if (cnt_q[i] == '0) begin
          err_d = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - CNT_WIDTH'(1);
        end
      end
    end
  end

  // Saturating count of stalled cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + PERF_WIDTH'(1);
    end
  end

  // Busy flags are a pure view of the registered counters.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      busy[i] = (cnt_q[i] != '0);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign err       = err_q;

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= '0;
      end
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard. A reference model predicts stall
// and post-edge state for every driven cycle; predictions and observations
// are queued and compared per scenario.
module tb_reg_scoreboard;

  localparam int CW = 2;
  localparam int PW = 4;  // small perf counter so saturation is reachable
  localparam int CMAX = (1 << CW) - 1;
  localparam int PMAX = (1 << PW) - 1;

  typedef struct {
    logic          stall;
    logic [7:0]    busy;
    logic          err;
    logic [PW-1:0] scnt;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          issue_valid = 0, issue_wr = 0, src1_used = 0, src2_used = 0;
  logic          wb_valid = 0, flush = 0;
  logic [2:0]    issue_dst = 0, src1_sel = 0, src2_sel = 0, wb_sel = 0;
  logic          stall, err;
  logic [7:0]    busy;
  logic [PW-1:0] stall_cnt;

  int   mcnt [8];
  logic merr;
  int   mscnt;
  obs_t exp_q[$];
  obs_t act_q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  reg_scoreboard #(
    .CNT_WIDTH (CW),
    .PERF_WIDTH(PW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .issue_valid(issue_valid),
    .issue_wr   (issue_wr),
    .issue_dst  (issue_dst),
    .src1_used  (src1_used),
    .src1_sel   (src1_sel),
    .src2_used  (src2_used),
    .src2_sel   (src2_sel),
    .wb_valid   (wb_valid),
    .wb_sel     (wb_sel),
    .flush      (flush),
    .stall      (stall),
    .busy       (busy),
    .stall_cnt  (stall_cnt),
    .err        (err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_busy();
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = (mcnt[i] != 0);
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mcnt[i] = 0;
    merr  = 1'b0;
    mscnt = 0;
  endtask

  // Drive one cycle, push the predicted observation, record the actual one.
  task automatic cyc(input logic iv, input logic iw, input logic [2:0] d,
                     input logic s1u, input logic [2:0] s1,
                     input logic s2u, input logic [2:0] s2,
                     input logic wv, input logic [2:0] ws, input logic fl);
    obs_t e, a;
    logic ms, acc, inc, dec;
    @(negedge clk);
    issue_valid = iv; issue_wr = iw; issue_dst = d;
    src1_used = s1u; src1_sel = s1; src2_used = s2u; src2_sel = s2;
    wb_valid = wv; wb_sel = ws; flush = fl;
    ms  = iv & ~fl & ((s1u & (mcnt[s1] != 0)) | (s2u & (mcnt[s2] != 0)) |
                      (iw & (mcnt[d] == CMAX)));
    acc = iv & ~ms & ~fl;
    if (fl) begin
      for (int i = 0; i < 8; i++) mcnt[i] = 0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        inc = acc & iw & (d == 3'(i));
        dec = wv & (ws == 3'(i));
        if (inc && !dec) mcnt[i]++;
        else if (dec && !inc) begin
          if (mcnt[i] == 0) merr = 1'b1;
          else mcnt[i]--;
        end
      end
    end
    if (ms && mscnt < PMAX) mscnt++;
    e.stall = ms; e.busy = model_busy(); e.err = merr; e.scnt = PW'(mscnt);
    exp_q.push_back(e);
    #1 a.stall = stall;
    @(posedge clk);
    #1 a.busy = busy; a.err = err; a.scnt = stall_cnt;
    act_q.push_back(a);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    issue_valid = 1; src1_used = 1; src1_sel = 3; issue_wr = 1; issue_dst = 3;
    #1;
    n_chk++;
    if (stall !== 1'b0) $display("FAIL reset_stall got=%b want=0", stall);
    else n_pass++;
    n_chk++;
    if ({busy, err, stall_cnt} !== '0)
      $display("FAIL reset_state busy=%h err=%b scnt=%0d want all zero", busy, err, stall_cnt);
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst = 0; issue_valid = 0; src1_used = 0; issue_wr = 0;
    idle();
    while (exp_q.size() > 0) begin
      obs_t e = exp_q.pop_front();
      obs_t a = act_q.pop_front();
      n_chk++;
      if ({a.busy, a.err, a.scnt} !== {e.busy, e.err, e.scnt})
        $display("FAIL reset_idle busy=%h err=%b scnt=%0d want busy=%h err=%b scnt=%0d",
                 a.busy, a.err, a.scnt, e.busy, e.err, e.scnt);
      else n_pass++;
    end
  endtask

  task automatic test_raw_stall();
    cyc(1, 1, 2, 0, 0, 0, 0, 0, 0, 0);          // write R2
    for (int k = 0; k < 3; k++)
      cyc(1, 0, 0, 1, 2, 0, 0, 0, 0, 0);        // read R2 -> stall
    cyc(1, 0, 0, 0, 0, 1, 2, 1, 2, 0);          // src2 R2, retiring now: still stall
    cyc(1, 0, 0, 1, 2, 0, 0, 0, 0, 0);          // clears
    while (exp_q.size() > 0) begin
      obs_t e = exp_q.pop_front();
      obs_t a = act_q.pop_front();
      n_chk++;
      if (a.stall !== e.stall) $display("FAIL raw_stall got=%b want=%b", a.stall, e.stall);
      else n_pass++;
      n_chk++;
      if ({a.busy, a.err, a.scnt} !== {e.busy, e.err, e.scnt})
        $display("FAIL raw_state busy=%h err=%b scnt=%0d want busy=%h err=%b scnt=%0d",
                 a.busy, a.err, a.scnt, e.busy, e.err, e.scnt);
      else n_pass++;
    end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 4; k++)
      cyc(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);        // fourth must stall at MAX
    cyc(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);          // still full
    for (int k = 0; k < 3; k++)
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 5, 0);        // exactly three retires empty it
    while (exp_q.size() > 0) begin
      obs_t e = exp_q.pop_front();
      obs_t a = act_q.pop_front();
      n_chk++;
      if (a.stall !== e.stall) $display("FAIL sat_stall got=%b want=%b", a.stall, e.stall);
      else n_pass++;
      n_chk++;
      if ({a.busy, a.err, a.scnt} !== {e.busy, e.err, e.scnt})
        $display("FAIL sat_state busy=%h err=%b scnt=%0d want busy=%h err=%b scnt=%0d",
                 a.busy, a.err, a.scnt, e.busy, e.err, e.scnt);
      else n_pass++;
    end
  endtask

  task automatic test_same_reg();
    cyc(1, 1, 1, 0, 0, 0, 0, 1, 1, 0);          // cnt 0: issue covers retire, no err
    cyc(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);          // cnt[1]=1
    cyc(1, 1, 1, 0, 0, 0, 0, 1, 1, 0);          // net unchanged
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);          // back to 0
    while (exp_q.size() > 0) begin
      obs_t e = exp_q.pop_front();
      obs_t a = act_q.pop_front();
      n_chk++;
      if (a.stall !== e.stall) $display("FAIL same_stall got=%b want=%b", a.stall, e.stall);
      else n_pass++;
      n_chk++;
      if ({a.busy, a.err, a.scnt} !== {e.busy, e.err, e.scnt})
        $display("FAIL same_state busy=%h err=%b scnt=%0d want busy=%h err=%b scnt=%0d",
                 a.busy, a.err, a.scnt, e.busy, e.err, e.scnt);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    cyc(1, 1, 4, 0, 0, 0, 0, 0, 0, 0);          // cnt[4]=1
    cyc(1, 1, 7, 1, 0, 0, 0, 1, 4, 0);          // issue R7, retire R4 together
    cyc(1, 1, 6, 0, 0, 1, 7, 0, 0, 0);          // src2 R7 busy -> stall, R6 not written
    cyc(1, 1, 6, 1, 4, 0, 0, 1, 7, 0);          // R4 free now, issue R6 + retire R7
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 6, 0);
    while (exp_q.size() > 0) begin
      obs_t e = exp_q.pop_front();
      obs_t a = act_q.pop_front();
      n_chk++;
      if (a.stall !== e.stall) $display("FAIL b2b_stall got=%b want=%b", a.stall, e.stall);
      else n_pass++;
      n_chk++;
      if ({a.busy, a.err, a.scnt} !== {e.busy, e.err, e.scnt})
        $display("FAIL b2b_state busy=%h err=%b scnt=%0d want busy=%h err=%b scnt=%0d",
                 a.busy, a.err, a.scnt, e.busy, e.err, e.scnt);
      else n_pass++;
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 8; k++)
      cyc(1, 1, 3'(k), 0, 0, 0, 0, 0, 0, 0);    // busy = FF
    cyc(1, 1, 2, 1, 3, 1, 5, 1, 6, 1);          // flush beats issue and wb
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);          // wb on empty during flush: no err
    cyc(1, 0, 0, 1, 2, 0, 0, 0, 0, 0);          // R2 readable again
    while (exp_q.size() > 0) begin
      obs_t e = exp_q.pop_front();
      obs_t a = act_q.pop_front();
      n_chk++;
      if (a.stall !== e.stall) $display("FAIL flush_stall got=%b want=%b", a.stall, e.stall);
      else n_pass++;
      n_chk++;
      if ({a.busy, a.err, a.scnt} !== {e.busy, e.err, e.scnt})
        $display("FAIL flush_state busy=%h err=%b scnt=%0d want busy=%h err=%b scnt=%0d",
                 a.busy, a.err, a.scnt, e.busy, e.err, e.scnt);
      else n_pass++;
    end
  endtask

  task automatic test_err();
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 6, 0);          // retire with nothing pending
    cyc(1, 1, 6, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 6, 0);          // valid retire, err stays
    cyc(1, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    while (exp_q.size() > 0) begin
      obs_t e = exp_q.pop_front();
      obs_t a = act_q.pop_front();
      n_chk++;
      if (a.stall !== e.stall) $display("FAIL err_stall got=%b want=%b", a.stall, e.stall);
      else n_pass++;
      n_chk++;
      if ({a.busy, a.err, a.scnt} !== {e.busy, e.err, e.scnt})
        $display("FAIL err_state busy=%h err=%b scnt=%0d want busy=%h err=%b scnt=%0d",
                 a.busy, a.err, a.scnt, e.busy, e.err, e.scnt);
      else n_pass++;
    end
  endtask

  task automatic test_stall_sat();
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < PMAX + 3; k++)
      cyc(1, 0, 0, 1, 0, 1, 0, 0, 0, 0);        // hold stall past saturation
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    while (exp_q.size() > 0) begin
      obs_t e = exp_q.pop_front();
      obs_t a = act_q.pop_front();
      n_chk++;
      if (a.stall !== e.stall) $display("FAIL psat_stall got=%b want=%b", a.stall, e.stall);
      else n_pass++;
      n_chk++;
      if ({a.busy, a.err, a.scnt} !== {e.busy, e.err, e.scnt})
        $display("FAIL psat_state busy=%h err=%b scnt=%0d want busy=%h err=%b scnt=%0d",
                 a.busy, a.err, a.scnt, e.busy, e.err, e.scnt);
      else n_pass++;
    end
  endtask

  task automatic test_midrun_reset();
    cyc(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);          // cnt[3]=2
    while (exp_q.size() > 0) begin
      obs_t e = exp_q.pop_front();
      obs_t a = act_q.pop_front();
      n_chk++;
      if ({a.busy, a.err, a.scnt} !== {e.busy, e.err, e.scnt})
        $display("FAIL pre_rst busy=%h err=%b scnt=%0d want busy=%h err=%b scnt=%0d",
                 a.busy, a.err, a.scnt, e.busy, e.err, e.scnt);
      else n_pass++;
    end
    @(negedge clk);
    issue_valid = 1; issue_wr = 0; src1_used = 1; src1_sel = 3; wb_valid = 0; flush = 0;
    #1 rst = 1;
    #1;
    n_chk++;
    if ({busy, err, stall_cnt} !== '0)
      $display("FAIL midrst_state busy=%h err=%b scnt=%0d want all zero", busy, err, stall_cnt);
    else n_pass++;
    n_chk++;
    if (stall !== 1'b0) $display("FAIL midrst_stall got=%b want=0", stall);
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst = 0;
    cyc(1, 0, 0, 1, 3, 0, 0, 0, 0, 0);          // R3 no longer pending
    while (exp_q.size() > 0) begin
      obs_t e = exp_q.pop_front();
      obs_t a = act_q.pop_front();
      n_chk++;
      if (a.stall !== e.stall) $display("FAIL post_rst_stall got=%b want=%b", a.stall, e.stall);
      else n_pass++;
      n_chk++;
      if ({a.busy, a.err, a.scnt} !== {e.busy, e.err, e.scnt})
        $display("FAIL post_rst busy=%h err=%b scnt=%0d want busy=%h err=%b scnt=%0d",
                 a.busy, a.err, a.scnt, e.busy, e.err, e.scnt);
      else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_raw_stall();
    test_saturate();
    test_same_reg();
    test_back_to_back();
    test_flush();
    test_err();
    test_stall_sat();
    test_midrun_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
